// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared types for the activation/weight
// buffer slice.
package ibuf_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } ibuf_state_e;

    localparam int REUSE_W = 4;

    localparam int DATA_W_DEF = 32;
    localparam int LANES_DEF  = 4;

    typedef struct packed {
        logic [LANES_DEF-1:0]            zmask;
        logic [LANES_DEF*DATA_W_DEF-1:0] words;
    } ibuf_entry_t;

endpackage

// File: rtl/ibuf_bank_if.sv
// ibuf_bank_if: write/read handshakes of the
// input activation buffer.
interface ibuf_bank_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4
);

    logic                    wr_valid;
    logic                    wr_ready;
    logic [LANES*DATA_W-1:0] wr_data;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [LANES*DATA_W-1:0] rd_data;
    logic [LANES-1:0]        rd_zero_mask;
    logic                    rd_last;

    modport master (
        output wr_valid,
        output wr_data,
        output rd_ready,
        input  wr_ready,
        input  rd_valid,
        input  rd_data,
        input  rd_zero_mask,
        input  rd_last
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  rd_ready,
        output wr_ready,
        output rd_valid,
        output rd_data,
        output rd_zero_mask,
        output rd_last
    );

endinterface

// File: rtl/ibuf_zero_detect.sv
// ibuf_zero_detect: per-lane all-zero reduction,
// shared with the weight buffer.
module ibuf_zero_detect #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic [LANES*DATA_W-1:0] data,
    output logic [LANES-1:0]        zmask
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign zmask[i] = ~|data[i*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/ibuf_bank.sv
// ibuf_bank: multi-lane FWFT activation buffer with
// per-lane zero tagging and entry replay.
module ibuf_bank
    import ibuf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               flush,
    input  logic [REUSE_W-1:0] cfg_reuse,
    ibuf_bank_if.slave         bus,
    output logic [CNT_W-1:0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [LANES-1:0]        zmask;
        logic [LANES*DATA_W-1:0] words;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [REUSE_W-1:0] rcnt;
    logic [REUSE_W-1:0] reuse_lat;
    logic [CNT_W-1:0]   occ;
    logic [LANES-1:0]   wr_zmask;
    logic               wr_fire;
    logic               pop;
    logic               head_done;
    logic               free;
    logic               lat_load;
    ibuf_state_e        state;
    ibuf_state_e        state_nxt;

    ibuf_zero_detect #(
        .DATA_W(DATA_W),
        .LANES (LANES)
    ) u_zd (
        .data (bus.wr_data),
        .zmask(wr_zmask)
    );

    assign bus.wr_ready = (occ != CNT_W'(DEPTH)) && !flush;
    assign bus.rd_valid = (occ != '0);
    assign wr_fire      = bus.wr_valid && bus.wr_ready;
    assign pop          = bus.rd_valid && bus.rd_ready;
    assign head_done    = (rcnt == reuse_lat);
    assign free         = pop && head_done;
    assign bus.rd_last  = bus.rd_valid && head_done;
    assign occupancy    = occ;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_fire) state_nxt = ACTIVE;
                end
                ACTIVE: begin
                    if (free && occ == CNT_W'(1) && !wr_fire)
                        state_nxt = IDLE;
                end
            endcase
        end
    end

    // Replay count may only change while the buffer is empty and quiet
    always_comb begin
        lat_load = (state == IDLE) && !wr_fire && !flush;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wptr      <= '0;
            rptr      <= '0;
            rcnt      <= '0;
            occ       <= '0;
            reuse_lat <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            rcnt <= '0;
            occ  <= '0;
        end else begin
            if (wr_fire) wptr <= wptr + 1'b1;
            if (free) begin
                rptr <= rptr + 1'b1;
                rcnt <= '0;
            end else if (pop) begin
                rcnt <= rcnt + 1'b1;
            end
            occ <= occ + CNT_W'(wr_fire) - CNT_W'(free);
            if (lat_load) reuse_lat <= cfg_reuse;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wptr] <= '{zmask: wr_zmask, words: bus.wr_data};
        end
    end

    assign head = mem[rptr];

    always_comb begin
        bus.rd_data      = '0;
        bus.rd_zero_mask = '0;
        if (bus.rd_valid) begin
            bus.rd_zero_mask = head.zmask;
            for (int i = 0; i < LANES; i++) begin
                if (!head.zmask[i])
                    bus.rd_data[i*DATA_W +: DATA_W] =
                        head.words[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
